// File: rtl/fifo_unpacker.sv
// Pops 32-bit words from a synchronous FIFO and replays them as narrow beats on a valid/ready stream.
// Optional even-parity output on each beat when FIFO_UNPACKER_PARITY_EN is defined.
module fifo_unpacker #(
    parameter int DATA_W    = 32,
    parameter int BEAT_W    = 8,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  words_sent
`ifdef FIFO_UNPACKER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int N     = DATA_W / BEAT_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   beatIdx_q, beatIdx_d;
    logic [DATA_W-1:0]  shiftReg_q, shiftReg_d;
    logic [CNT_W-1:0]   wordCount_q, wordCount_d;
    logic               handshake;
    logic               lastBeat;
    logic [IDX_W-1:0]   beatSel;

    assign handshake = (state_q == SEND) && out_ready;
    assign lastBeat  = (beatIdx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins over every transition, including a final-beat handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!fifo_empty) state_d = FETCH;
                FETCH:   state_d = SEND;
                SEND:    if (handshake && lastBeat) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_rd_en = (state_q == IDLE) && !fifo_empty && !flush;
        out_valid  = (state_q == SEND);
        busy       = (state_q != IDLE);
    end

    always_comb begin
        beatIdx_d   = beatIdx_q;
        shiftReg_d  = shiftReg_q;
        wordCount_d = wordCount_q;
        if (!flush) begin
            if (state_q == FETCH) begin
                shiftReg_d = fifo_data;
                beatIdx_d  = '0;
            end else if (handshake) begin
                if (lastBeat) begin
                    wordCount_d = wordCount_q + CNT_W'(1);
                end else begin
                    beatIdx_d = beatIdx_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beatIdx_q   <= '0;
            shiftReg_q  <= '0;
            wordCount_q <= '0;
        end else begin
            beatIdx_q   <= beatIdx_d;
            shiftReg_q  <= shiftReg_d;
            wordCount_q <= wordCount_d;
        end
    end

    // The slice only moves on a handshake, so data is stable under backpressure.
    assign beatSel    = (MSB_FIRST != 0) ? (LAST_IDX - beatIdx_q) : beatIdx_q;
    assign out_data   = shiftReg_q[int'(beatSel)*BEAT_W +: BEAT_W];
    assign words_sent = wordCount_q;

`ifdef FIFO_UNPACKER_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_fifo_unpacker.sv
// Randomized + directed bench for fifo_unpacker: an LSB-first and an MSB-first (3-bit counter) instance
// share one FIFO stream and are checked against a word-level model of the unpacking rules.
module tb_fifo_unpacker;

    logic        clk;
    logic        rst;
    logic        fifoEmpty;
    logic [31:0] fifoData;
    logic        flush;
    logic        outReady;

    logic        rdEn0, rdEn1;
    logic        valid0, valid1;
    logic [7:0]  data0, data1;
    logic        busy0, busy1;
    logic [15:0] cnt0;
    logic [2:0]  cnt1;
`ifdef FIFO_UNPACKER_PARITY_EN
    logic        parity0, parity1;
`endif

    int total = 0;
    int bad   = 0;

    // Word-level reference: a FIFO queue, the word being unpacked and how many beats of it were taken.
    logic [31:0] fifoQ[$];
    logic [31:0] curWord;
    bit          fetchWait;
    bit          active;
    int          beatsDone;
    int          wordsDone;

    fifo_unpacker #(.DATA_W(32), .BEAT_W(8), .MSB_FIRST(0), .CNT_W(16)) dutLsb (
        .clk(clk), .rst(rst), .fifo_empty(fifoEmpty), .fifo_rd_en(rdEn0), .fifo_data(fifoData),
        .flush(flush), .out_valid(valid0), .out_ready(outReady), .out_data(data0), .busy(busy0),
        .words_sent(cnt0)
`ifdef FIFO_UNPACKER_PARITY_EN
        , .out_parity(parity0)
`endif
    );

    fifo_unpacker #(.DATA_W(32), .BEAT_W(8), .MSB_FIRST(1), .CNT_W(3)) dutMsb (
        .clk(clk), .rst(rst), .fifo_empty(fifoEmpty), .fifo_rd_en(rdEn1), .fifo_data(fifoData),
        .flush(flush), .out_valid(valid1), .out_ready(outReady), .out_data(data1), .busy(busy1),
        .words_sent(cnt1)
`ifdef FIFO_UNPACKER_PARITY_EN
        , .out_parity(parity1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        fetchWait = 0;
        active    = 0;
        beatsDone = 0;
        wordsDone = 0;
    endtask

    // One clock cycle: drive at the falling edge, check after settling, advance the model at the rising edge.
    task automatic applyStimulus(input bit rstN, input bit rdy, input bit fl);
        bit          expRd;
        bit          expIdle;
        logic [31:0] expD0, expD1;
        @(negedge clk);
        rst       = rstN;
        outReady  = rdy;
        flush     = fl;
        fifoEmpty = (fifoQ.size() == 0);
        fifoData  = fetchWait ? curWord : $urandom();
        if (!rstN) modelReset();
        #1;
        expIdle = !fetchWait && !active;
        expRd   = expIdle && (fifoQ.size() != 0) && !fl;
        expD0   = (curWord >> (8 * beatsDone)) & 32'hFF;
        expD1   = (curWord >> (8 * (3 - beatsDone))) & 32'hFF;
        checkOutput("rdEnLsb", 32'(rdEn0), 32'(expRd));
        checkOutput("rdEnMsb", 32'(rdEn1), 32'(expRd));
        checkOutput("validLsb", 32'(valid0), 32'(active));
        checkOutput("validMsb", 32'(valid1), 32'(active));
        checkOutput("busyLsb", 32'(busy0), 32'(!expIdle));
        checkOutput("busyMsb", 32'(busy1), 32'(!expIdle));
        checkOutput("cntLsb", 32'(cnt0), 32'(wordsDone % 65536));
        checkOutput("cntMsb", 32'(cnt1), 32'(wordsDone % 8));
        if (active) begin
            checkOutput("dataLsb", 32'(data0), expD0);
            checkOutput("dataMsb", 32'(data1), expD1);
`ifdef FIFO_UNPACKER_PARITY_EN
            checkOutput("parityLsb", 32'(parity0), 32'(^expD0));
            checkOutput("parityMsb", 32'(parity1), 32'(^expD1));
`endif
        end
        if (!rstN) begin
            checkOutput("rstDataLsb", 32'(data0), 32'h0);
            checkOutput("rstDataMsb", 32'(data1), 32'h0);
`ifdef FIFO_UNPACKER_PARITY_EN
            checkOutput("rstParity", 32'(parity0), 32'h0);
`endif
        end
        @(posedge clk);
        if (rstN) begin
            if (fl) begin
                fetchWait = 0;
                active    = 0;
            end else if (expRd) begin
                curWord   = fifoQ.pop_front();
                fetchWait = 1;
            end else if (fetchWait) begin
                fetchWait = 0;
                active    = 1;
                beatsDone = 0;
            end else if (active && rdy) begin
                beatsDone++;
                if (beatsDone == 4) begin
                    active = 0;
                    wordsDone++;
                end
            end
        end
    endtask

    initial begin
        bit flushed;
        int cyc;
        flush     = 1'b0;
        outReady  = 1'b0;
        fifoEmpty = 1'b1;
        fifoData  = '0;
        curWord   = '0;
        modelReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;

        // Reset held, then 10 idle cycles with an empty FIFO.
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0);

        // Single word with the sink always ready.
        fifoQ.push_back(32'h44332211);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("oneWordCount", 32'(cnt0), 32'd1);

        // Same word with a stalling sink.
        fifoQ.push_back(32'h44332211);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, (i % 3) == 0, 1'b0);

        // Back-to-back words.
        fifoQ.push_back(32'hAABBCCDD);
        fifoQ.push_back(32'h01020304);
        repeat (14) applyStimulus(1'b1, 1'b1, 1'b0);

        // Flush after the second beat, then the next word restarts at beat 0.
        fifoQ.push_back(32'hDEADBEEF);
        fifoQ.push_back(32'h12345678);
        flushed = 0;
        for (int i = 0; i < 20; i++) begin
            bit fl;
            fl = active && (beatsDone == 2) && !flushed;
            if (fl) flushed = 1;
            applyStimulus(1'b1, 1'b1, fl);
        end
        checkOutput("flushSeen", 32'(flushed), 32'd1);

        // Parity of beat 0x07.
        fifoQ.push_back(32'h00000007);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0);

        // Reset in the middle of a word: the word is lost, no re-read.
        fifoQ.push_back(32'hCAFEF00D);
        cyc = 0;
        while (!(active && beatsDone == 1) && cyc < 20) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            cyc++;
        end
        checkOutput("midWordReached", 32'(cyc < 20), 32'd1);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0);

        // Random traffic, backpressure and occasional flushes; the 3-bit counter wraps many times.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && fifoQ.size() < 8) fifoQ.push_back($urandom());
            applyStimulus(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        repeat (60) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("drained", 32'(fifoQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
